// File: rtl/dope_engine_if.sv
// ---------------------------------------------------------------------------
// dope_engine_if : control, frame-buffer read and write bus of dope_engine
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface dope_engine_if #(
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 16,
  parameter int OFF_W  = 4
);
  logic              start;
  logic              buffer_select;
  logic [2:0]        op;
  logic [OFF_W-1:0]  offset;
  logic [PIX_W-1:0]  fill_pixel;
  logic [PIX_W-1:0]  fb0_q;
  logic [PIX_W-1:0]  fb1_q;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;
  logic              fb0_we;
  logic              fb1_we;
  logic              busy;
  logic              done;

  modport master (
    output start, buffer_select, op, offset, fill_pixel, fb0_q, fb1_q,
    input  rd_addr, wr_addr, wr_data, fb0_we, fb1_we, busy, done
  );

  modport slave (
    input  start, buffer_select, op, offset, fill_pixel, fb0_q, fb1_q,
    output rd_addr, wr_addr, wr_data, fb0_we, fb1_we, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/dope_engine.sv
// ---------------------------------------------------------------------------
// dope_engine : streams one frame buffer through a pixel op into the other
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dope_engine #(
  parameter int R_BITS  = 3,
  parameter int G_BITS  = 3,
  parameter int B_BITS  = 2,
  parameter int ADDR_W  = 16,
  parameter int NUM_PIX = 19200,
  parameter int OFF_W   = 4
) (
  input  logic         Clk,
  input  logic         Reset_n,
  dope_engine_if.slave bus
);

  localparam int PIX_W = R_BITS + G_BITS + B_BITS;
  localparam int MW    = (R_BITS > G_BITS) ? ((R_BITS > B_BITS) ? R_BITS : B_BITS)
                                           : ((G_BITS > B_BITS) ? G_BITS : B_BITS);
  localparam int CW    = ((MW > OFF_W) ? MW : OFF_W) + 2;
  localparam int SW    = ((R_BITS > G_BITS) ? R_BITS : G_BITS) + 2;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIX - 1);

  localparam logic [2:0] OP_FILL   = 3'd0;
  localparam logic [2:0] OP_INVERT = 3'd1;
  localparam logic [2:0] OP_GREY   = 3'd2;
  localparam logic [2:0] OP_OFFSET = 3'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  logic [2:0]        lat_op;
  logic [OFF_W-1:0]  lat_off;
  logic [PIX_W-1:0]  lat_fill;
  logic              lat_sel;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic              we0;
  logic              we1;
  logic              busy;
  logic              done;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      lat_op   <= '0;
      lat_off  <= '0;
      lat_fill <= '0;
      lat_sel  <= 1'b0;
      rd_addr  <= '0;
      wr_addr  <= '0;
      we0      <= 1'b0;
      we1      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      we0  <= 1'b0;
      we1  <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            lat_op   <= bus.op;
            lat_off  <= bus.offset;
            lat_fill <= bus.fill_pixel;
            lat_sel  <= bus.buffer_select;
            rd_addr  <= '0;
            busy     <= 1'b1;
            if (bus.op[2]) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          // Write-back of the address issued this cycle lands next cycle
          wr_addr <= rd_addr;
          we0     <= ~lat_sel;
          we1     <= lat_sel;
          if (rd_addr == LAST_ADDR) begin
            state   <= DRAIN;
            rd_addr <= '0;
          end else begin
            rd_addr <= rd_addr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [PIX_W-1:0] src;
  logic [SW-1:0]    grey_half;
  logic [CW-1:0]    off_ext;
  logic [PIX_W-1:0] off_pix;
  logic [PIX_W-1:0] grey_pix;
  logic [PIX_W-1:0] pix;

  assign src       = lat_sel ? bus.fb0_q : bus.fb1_q;
  assign off_ext   = {{(CW-OFF_W){lat_off[OFF_W-1]}}, lat_off};
  assign grey_half = SW'((SW'(src[PIX_W-1 -: R_BITS]) + SW'(src[B_BITS +: G_BITS])
                        + SW'(src[B_BITS-1:0])) >> 1);

  for (genvar c = 0; c < 3; c++) begin : g_chan
    localparam int W   = (c == 0) ? R_BITS : ((c == 1) ? G_BITS : B_BITS);
    localparam int LSB = (c == 0) ? (G_BITS + B_BITS) : ((c == 1) ? B_BITS : 0);
    localparam logic [CW-1:0] CMAX = CW'((1 << W) - 1);

    logic signed [CW-1:0] sum;
    logic [CW-1:0]        grey_ext;
    logic [W-1:0]         off_o;
    logic [W-1:0]         grey_o;

    // CW leaves headroom so the signed sum never wraps before saturation
    assign sum      = $signed(CW'(src[LSB +: W])) + $signed(off_ext);
    assign grey_ext = CW'(grey_half);

    always_comb begin
      off_o  = sum[W-1:0];
      grey_o = grey_ext[W-1:0];
      if (sum[CW-1])
        off_o = '0;
      else if (sum > $signed(CMAX))
        off_o = '1;
      if (grey_ext > CMAX)
        grey_o = '1;
    end

    assign off_pix[LSB +: W]  = off_o;
    assign grey_pix[LSB +: W] = grey_o;
  end

  always_comb begin
    pix = '0;
    case (lat_op)
      OP_FILL:   pix = lat_fill;
      OP_INVERT: pix = ~src;
      OP_GREY:   pix = grey_pix;
      OP_OFFSET: pix = off_pix;
      default:   pix = '0;
    endcase
  end

  assign bus.rd_addr = rd_addr;
  assign bus.wr_addr = wr_addr;
  assign bus.wr_data = (we0 | we1) ? pix : '0;
  assign bus.fb0_we  = we0;
  assign bus.fb1_we  = we1;
  assign bus.busy    = busy;
  assign bus.done    = done;

endmodule

`default_nettype wire

// File: tb/tb_dope_engine.sv
// ---------------------------------------------------------------------------
// tb_dope_engine : directed self-checking bench for dope_engine (16-pixel frame)
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dope_engine;

  localparam int NP = 16;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  logic [7:0] fb0 [NP];
  logic [7:0] fb1 [NP];

  dope_engine_if #(.PIX_W(8), .ADDR_W(16), .OFF_W(4)) bif ();

  dope_engine #(
    .R_BITS(3), .G_BITS(3), .B_BITS(2), .ADDR_W(16), .NUM_PIX(NP), .OFF_W(4)
  ) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read frame buffers: data appears the cycle after the address
  always @(posedge clk) begin
    bif.fb0_q <= fb0[bif.rd_addr[3:0]];
    bif.fb1_q <= fb1[bif.rd_addr[3:0]];
    if (bif.fb0_we) fb0[bif.wr_addr[3:0]] <= bif.wr_data;
    if (bif.fb1_we) fb1[bif.wr_addr[3:0]] <= bif.wr_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_pass(input logic [2:0] o, input logic sel, input logic [3:0] off,
                          input logic [7:0] fill, input int poke,
                          output int cyc, output int nwr, output int bad);
    cyc = 0;
    nwr = 0;
    bad = 0;
    @(negedge clk);
    bif.start         = 1'b1;
    bif.op            = o;
    bif.buffer_select = sel;
    bif.offset        = off;
    bif.fill_pixel    = fill;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        bif.start         = 1'b0;
        bif.op            = o ^ 3'b001;
        bif.buffer_select = ~sel;
        bif.offset        = ~off;
        bif.fill_pixel    = ~fill;
      end
      if (poke > 1 && cyc == poke) begin
        bif.start = 1'b1;
        bif.op    = 3'b111;
      end else if (poke > 1 && cyc == poke + 1) begin
        bif.start = 1'b0;
      end
      if (bif.fb0_we && bif.fb1_we) bad++;
      if (bif.fb0_we || bif.fb1_we) begin
        nwr++;
        if (cyc == 1) bad++;
        if (bif.wr_addr != 16'(cyc - 2)) bad++;
        if (sel ? bif.fb0_we : bif.fb1_we) bad++;
      end
      if (!o[2] && cyc <= NP && bif.rd_addr != 16'(cyc - 1)) bad++;
      if (bif.busy !== 1'b1) bad++;
      if (bif.done) break;
    end
    bif.start = 1'b0;
  endtask

  initial begin
    int cyc, nwr, bad, nbad;
    n_checks = 0;
    n_errors = 0;
    bif.start = 0; bif.op = 0; bif.buffer_select = 0; bif.offset = 0; bif.fill_pixel = 0;
    for (int i = 0; i < NP; i++) begin
      fb0[i] = 8'h00;
      fb1[i] = 8'h5A;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bif.busy), 0);
    check("rst_done", 32'(bif.done), 0);
    check("rst_we", {30'd0, bif.fb1_we, bif.fb0_we}, 0);
    check("rst_addr", {bif.rd_addr, bif.wr_addr}, 0);
    check("rst_wdata", 32'(bif.wr_data), 0);
    rst_n = 1'b1;

    // Fill into fb0; fill_pixel is changed after start and must not leak in
    run_pass(3'b000, 1'b0, 4'd0, 8'hA5, 0, cyc, nwr, bad);
    check("fill_cycles", cyc, NP + 2);
    check("fill_writes", nwr, NP);
    check("fill_proto", bad, 0);
    nbad = 0;
    for (int i = 0; i < NP; i++) if (fb0[i] !== 8'hA5) nbad++;
    check("fill_data", nbad, 0);
    check("fill_fb1_untouched", 32'(fb1[7]), 32'h5A);
    @(negedge clk);
    check("idle_busy", 32'(bif.busy), 0);
    check("idle_done", 32'(bif.done), 0);

    // Invert fb0 -> fb1, with a start poked mid-run that must be dropped
    for (int i = 0; i < NP; i++) fb0[i] = 8'(i * 17 + 3);
    fb0[3] = 8'b101_010_01;
    run_pass(3'b001, 1'b1, 4'd0, 8'h00, 5, cyc, nwr, bad);
    check("inv_cycles", cyc, NP + 2);
    check("inv_writes", nwr, NP);
    check("inv_proto", bad, 0);
    check("inv_pix3", 32'(fb1[3]), 32'b010_101_10);
    nbad = 0;
    for (int i = 0; i < NP; i++) if (i != 3 && fb1[i] !== ~8'(i * 17 + 3)) nbad++;
    check("inv_all", nbad, 0);
    repeat (4) @(negedge clk);
    check("poke_not_queued", 32'(bif.busy), 0);

    // Offset +3 and -4, saturating high and low
    fb1[0] = 8'b110_001_10;
    fb1[1] = 8'b010_101_01;
    run_pass(3'b011, 1'b0, 4'b0011, 8'h00, 0, cyc, nwr, bad);
    check("offp_cycles", cyc, NP + 2);
    check("offp_pix", 32'(fb0[0]), 32'b111_100_11);
    run_pass(3'b011, 1'b0, 4'b1100, 8'h00, 0, cyc, nwr, bad);
    check("offn_proto", bad, 0);
    check("offn_pix", 32'(fb0[1]), 32'b000_001_00);

    // Grey
    fb1[0] = 8'b111_111_11;
    fb1[1] = 8'b010_001_01;
    run_pass(3'b010, 1'b0, 4'd0, 8'h00, 0, cyc, nwr, bad);
    check("grey_writes", nwr, NP);
    check("grey_white", 32'(fb0[0]), 32'hFF);
    check("grey_mid", 32'(fb0[1]), 32'b010_010_10);

    // NOP: done on the next cycle, no writes
    run_pass(3'b111, 1'b0, 4'd0, 8'h00, 0, cyc, nwr, bad);
    check("nop_cycles", cyc, 1);
    check("nop_writes", nwr, 0);

    // Reset asserted while rd_addr = 7
    @(negedge clk);
    bif.start = 1'b1; bif.op = 3'b000; bif.buffer_select = 1'b0; bif.fill_pixel = 8'h11;
    @(negedge clk);
    bif.start = 1'b0;
    for (int i = 0; i < 40 && bif.rd_addr != 16'd7; i++) @(negedge clk);
    check("abort_reached7", 32'(bif.rd_addr), 7);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bif.busy), 0);
    check("abort_we", {30'd0, bif.fb1_we, bif.fb0_we}, 0);
    check("abort_addr", {bif.rd_addr, bif.wr_addr}, 0);
    check("abort_wdata", 32'(bif.wr_data), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nwr = 0;
    nbad = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bif.fb0_we || bif.fb1_we) nwr++;
      if (bif.done || bif.busy) nbad++;
    end
    check("abort_no_writes", nwr, 0);
    check("abort_no_done", nbad, 0);

    // Fresh pass after reset must restart at address 0
    run_pass(3'b000, 1'b1, 4'd0, 8'h3C, 0, cyc, nwr, bad);
    check("restart_cycles", cyc, NP + 2);
    check("restart_proto", bad, 0);
    check("restart_pix0", 32'(fb1[0]), 32'h3C);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dope_engine.md
DOPE_ENGINE -- requirements
Module: dope_engine

Interface
REQ-001 SHALL have parameter R_BITS, default 3, red channel width.
REQ-002 SHALL have parameter G_BITS, default 3, green channel width.
REQ-003 SHALL have parameter B_BITS, default 2, blue channel width; PIX_W = R_BITS+G_BITS+B_BITS.
REQ-004 SHALL have parameter ADDR_W, default 16, frame buffer address width.
REQ-005 SHALL have parameter NUM_PIX, default 19200, pixels per frame, range 1..2^ADDR_W.
REQ-006 SHALL have parameter OFF_W, default 4, width of the signed two's-complement offset.
REQ-007 Ports, one clock, asynchronous active-low reset:
- Clk  in  1  sole clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- buffer_select  in  1  0: read fb1, write fb0; 1: read fb0, write fb1.
- op  in  3  000 fill, 001 invert, 010 grey, 011 offset, others NOP.
- offset  in  OFF_W  signed per-channel offset.
- fill_pixel  in  PIX_W  constant pixel for fill.
- fb0_q  in  PIX_W  fb0 read data, valid 1 cycle after rd_addr.
- fb1_q  in  PIX_W  fb1 read data, valid 1 cycle after rd_addr.
- rd_addr  out  ADDR_W  read address, shared by both buffers.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  PIX_W  write pixel.
- fb0_we  out  1  fb0 write enable.
- fb1_we  out  1  fb1 write enable.
- busy  out  1  high in every state except IDLE.
- done  out  1  single-cycle completion pulse.

Function
REQ-008 SHALL latch op, offset, fill_pixel, buffer_select on the Clk edge where start=1 in IDLE; changes afterwards SHALL NOT affect the running pass.
REQ-009 SHALL implement states IDLE, RUN, DRAIN, DONE: IDLE->RUN on start with a non-NOP op; IDLE->DONE on start with NOP; RUN->DRAIN after issuing address NUM_PIX-1; DRAIN->DONE; DONE->IDLE unconditionally.
REQ-010 In RUN, rd_addr SHALL equal 0,1,...,NUM_PIX-1 on successive cycles, one pixel per cycle, no stalls.
REQ-011 The write for address A SHALL occur exactly one cycle after rd_addr=A (RUN or DRAIN), wr_addr=A, on the destination buffer only.
REQ-012 From start to done SHALL take NUM_PIX+2 cycles for non-NOP ops and 1 cycle for NOP, with exactly NUM_PIX writes for non-NOP ops and none for NOP.
REQ-013 fb0_we and fb1_we SHALL never be high together and SHALL be 0 in IDLE, DONE and in RUN's first cycle.
REQ-014 Fill SHALL write the latched fill_pixel; source data SHALL be ignored.
REQ-015 Invert SHALL write the bitwise complement of the source pixel.
REQ-016 Grey SHALL compute s=(R+G+B), zero-extended to max(R_BITS,G_BITS)+2 bits; g=s>>1; each channel = min(g, channel max).
REQ-017 Offset SHALL add the sign-extended offset to each channel independently, saturating to 0 below and channel max above; no wrap-around.
REQ-018 A start asserted while busy=1 SHALL be ignored, not queued.
REQ-019 NUM_PIX=1 SHALL give RUN for exactly one cycle.

Reset
REQ-020 Reset_n=0 SHALL immediately and asynchronously force IDLE, busy=0, done=0, fb0_we=0, fb1_we=0, rd_addr=0, wr_addr=0, wr_data=0.
REQ-021 Reset mid-pass SHALL abandon the pass, make no further writes and produce no done; the next start after release SHALL begin again at address 0.

Verification
REQ-022 Fill, buffer_select=0, fill_pixel=8'hA5, NUM_PIX=16 -> fb0 addrs 0..15 = A5, fb1_we never high, done at cycle 18.
REQ-023 Invert, buffer_select=1, fb0 pixel 8'b101_010_01 -> fb1 receives 8'b010_101_10 at the same address, one cycle after the read.
REQ-024 Offset +3 on 8'b110_001_10 -> 8'b111_100_11; offset -4 on 8'b010_101_01 -> 8'b000_001_00 (saturation both ways).
REQ-025 Grey on 8'b111_111_11 -> s=17, g=8, output 8'hFF; on 8'b010_001_01 -> g=2, output 8'b010_010_10.
REQ-026 NOP start -> done next cycle, no writes; start during RUN ignored; Reset_n pulsed low at RUN address 7 -> writes cease, no done, outputs at reset values.
